// File: rtl/game_pkg.sv
// game_pkg: shared control-plane state encodings and default frame timing
package game_pkg;
  typedef enum logic [2:0] {
    S_WAIT_START = 3'd0,
    S_INIT       = 3'd1,
    S_MAP        = 3'd2,
    S_CHAR       = 3'd3,
    S_IDLE       = 3'd4,
    S_REG        = 3'd5,
    S_CHECK      = 3'd6,
    S_APPLY      = 3'd7
  } state_t;
  localparam int FRAME_CYCLES_DEF = 833_333;
  localparam int DRAW_TIMEOUT_DEF = 131_072;
endpackage

// File: rtl/game_control_if.sv
// game_control_if: strobe/done handshake and status between the game sequencer and its clients
interface game_control_if;
  logic        start;
  logic        map_draw_done;
  logic        char_draw_done;
  logic        init;
  logic        idle;
  logic        reg_action;
  logic        apply_action;
  logic        draw_map;
  logic        draw_char;
  logic        overrun;
  logic        draw_fault;
  logic [7:0]  skipped_frames;
  logic [15:0] frame_count;
  modport master (
    output start, map_draw_done, char_draw_done,
    input  init, idle, reg_action, apply_action, draw_map, draw_char,
           overrun, draw_fault, skipped_frames, frame_count
  );
  modport slave (
    input  start, map_draw_done, char_draw_done,
    output init, idle, reg_action, apply_action, draw_map, draw_char,
           overrun, draw_fault, skipped_frames, frame_count
  );
endinterface

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: free-running divider pulsing tick on the last cycle of each frame period
module frame_tick_gen
  import game_pkg::*;
#(
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);
  localparam int W = $clog2(FRAME_CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == W'(FRAME_CYCLES - 1);
  // wrap to zero after the tick cycle
  always_comb cnt_d = tick ? '0 : cnt_q + 1'b1;
  // divider register
  always_ff @(posedge clock) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/game_control.sv
// game_control: per-frame sequencer issuing renderer strobes, with overrun and hung-draw tracking
module game_control
  import game_pkg::*;
#(
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int DRAW_TIMEOUT = DRAW_TIMEOUT_DEF
) (
  input  logic           clock,
  input  logic           reset,
  game_control_if.slave  bus
);
  state_t      state_q, state_d;
  logic [16:0] dwell_q, dwell_d;
  logic        overrun_q, overrun_d;
  logic        draw_fault_q, draw_fault_d;
  logic [7:0]  skipped_q, skipped_d;
  logic [15:0] frame_q, frame_d;
  logic        tick, done, timeout, drop;
  frame_tick_gen #(.FRAME_CYCLES(FRAME_CYCLES)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );
  // next state, dwell and status; done is ignored on the first draw cycle and beats a coincident timeout
  always_comb begin
    done    = dwell_q != '0 && (state_q == S_MAP ? bus.map_draw_done : bus.char_draw_done);
    timeout = dwell_q == 17'(DRAW_TIMEOUT - 1);
    drop    = tick && state_q != S_IDLE;
    state_d = state_q;
    case (state_q)
      S_WAIT_START: state_d = bus.start ? S_INIT : S_WAIT_START;
      S_INIT:       state_d = S_MAP;
      S_MAP:        state_d = done ? S_CHAR : timeout ? S_IDLE : S_MAP;
      S_CHAR:       state_d = done || timeout ? S_IDLE : S_CHAR;
      S_IDLE:       state_d = tick ? S_REG : S_IDLE;
      S_REG:        state_d = S_CHECK;
      S_CHECK:      state_d = S_APPLY;
      S_APPLY:      state_d = S_MAP;
    endcase
    dwell_d      = state_d == state_q ? dwell_q + 1'b1 : '0;
    draw_fault_d = draw_fault_q || ((state_q == S_MAP || state_q == S_CHAR) && !done && timeout);
    overrun_d    = overrun_q || drop;
    skipped_d    = skipped_q + 8'(drop && skipped_q != 8'hff);
    frame_d      = frame_q + 16'(state_q == S_CHAR && done);
  end
  // state and status registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_WAIT_START;
      dwell_q      <= '0;
      overrun_q    <= 1'b0;
      draw_fault_q <= 1'b0;
      skipped_q    <= '0;
      frame_q      <= '0;
    end else begin
      state_q      <= state_d;
      dwell_q      <= dwell_d;
      overrun_q    <= overrun_d;
      draw_fault_q <= draw_fault_d;
      skipped_q    <= skipped_d;
      frame_q      <= frame_d;
    end
  end
  assign bus.init           = !reset && state_q == S_INIT;
  assign bus.idle           = !reset && state_q == S_IDLE;
  assign bus.reg_action     = !reset && state_q == S_REG;
  assign bus.apply_action   = !reset && state_q == S_APPLY;
  assign bus.draw_map       = !reset && state_q == S_MAP;
  assign bus.draw_char      = !reset && state_q == S_CHAR;
  assign bus.overrun        = overrun_q;
  assign bus.draw_fault     = draw_fault_q;
  assign bus.skipped_frames = skipped_q;
  assign bus.frame_count    = frame_q;
endmodule

// File: tb/tb_game_control.sv
// tb_game_control: randomized renderers against a cycle-level behavioural model of the game loop
module tb_game_control;
  localparam int FC = 40;
  localparam int TO = 50;
  typedef enum {P_WAIT, P_INIT, P_MAP, P_CHAR, P_IDLE, P_REG, P_GAP, P_APPLY} phase_t;
  logic clock, reset;
  game_control_if bus();
  game_control #(.FRAME_CYCLES(FC), .DRAW_TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );
  int total = 0, bad = 0;
  bit chk_en = 0;
  phase_t ph = P_WAIT;
  int cyc = 0, enter = 0, tcnt = 0, sk = 0, fc = 0;
  bit ov = 0, flt = 0;
  int mc = 0, ml = 0, cc = 0, cl = 0;
  bit mh = 0, ch = 0, cs = 0;
  initial clock = 0;
  always #5 clock = ~clock;
  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, a, e);
    end
  endtask
  task automatic model_step();
    bit tk;
    int d;
    if (reset) begin
      ph = P_WAIT; tcnt = 0; ov = 0; flt = 0; sk = 0; fc = 0;
    end else begin
      tk = tcnt == FC - 1;
      tcnt = tk ? 0 : tcnt + 1;
      d = cyc - enter;
      if (tk && ph != P_IDLE) begin
        ov = 1;
        if (sk < 255) sk++;
      end
      case (ph)
        P_WAIT:  if (bus.start) ph = P_INIT;
        P_INIT, P_APPLY: begin ph = P_MAP; enter = cyc + 1; end
        P_MAP: begin
          if (d > 0 && bus.map_draw_done) begin ph = P_CHAR; enter = cyc + 1; end
          else if (d >= TO - 1) begin ph = P_IDLE; flt = 1; end
        end
        P_CHAR: begin
          if (d > 0 && bus.char_draw_done) begin ph = P_IDLE; fc = (fc + 1) % 65536; end
          else if (d >= TO - 1) begin ph = P_IDLE; flt = 1; end
        end
        P_IDLE:  if (tk) ph = P_REG;
        P_REG:   ph = P_GAP;
        P_GAP:   ph = P_APPLY;
      endcase
    end
    cyc++;
  endtask
  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
  endtask
  function automatic int pick();
    return $urandom_range(0, 3) == 0 ? TO - 1 : $urandom_range(0, 12);
  endfunction
  task automatic renderers();
    if (bus.draw_map) begin
      if (mc == 0) begin ml = pick(); mh = $urandom_range(0, 7) == 0; end
      bus.map_draw_done = !mh && mc >= ml;
      mc++;
    end else begin
      mc = 0;
      bus.map_draw_done = $urandom_range(0, 15) == 0;
    end
    if (bus.draw_char) begin
      if (cc == 0) begin
        cl = pick(); ch = $urandom_range(0, 7) == 0; cs = $urandom_range(0, 5) == 0;
      end
      bus.char_draw_done = cs ? (cc > 0 && tcnt == FC - 1) : (!ch && cc >= cl);
      cc++;
    end else begin
      cc = 0;
      bus.char_draw_done = $urandom_range(0, 15) == 0;
    end
  endtask
  always @(negedge clock) begin
    if (chk_en) begin
      chk("init", bus.init, int'(ph == P_INIT && !reset));
      chk("idle", bus.idle, int'(ph == P_IDLE && !reset));
      chk("reg_action", bus.reg_action, int'(ph == P_REG && !reset));
      chk("apply_action", bus.apply_action, int'(ph == P_APPLY && !reset));
      chk("draw_map", bus.draw_map, int'(ph == P_MAP && !reset));
      chk("draw_char", bus.draw_char, int'(ph == P_CHAR && !reset));
      chk("overrun", bus.overrun, int'(ov));
      chk("draw_fault", bus.draw_fault, int'(flt));
      chk("skipped_frames", bus.skipped_frames, sk);
      chk("frame_count", bus.frame_count, fc);
    end
  end
  initial begin
    reset = 1;
    bus.start = 0;
    bus.map_draw_done = 0;
    bus.char_draw_done = 0;
    repeat (3) cycle();
    chk_en = 1;
    reset = 0;
    chk("rst_init", bus.init, 0);
    chk("rst_skipped", bus.skipped_frames, 0);
    chk("rst_frames", bus.frame_count, 0);
    chk("rst_overrun", bus.overrun, 0);
    bus.start = 1;
    cycle();
    chk("start_init", bus.init, 1);
    bus.start = 0;
    cycle();
    chk("init_to_map", bus.draw_map, 1);
    bus.map_draw_done = 1;
    cycle();
    chk("map_first_done_ignored", bus.draw_map, 1);
    cycle();
    chk("map_to_char", bus.draw_char, 1);
    bus.map_draw_done = 0;
    for (int i = 0; i < FC && tcnt != FC - 1; i++) cycle();
    bus.char_draw_done = 1;
    cycle();
    bus.char_draw_done = 0;
    chk("coinc_idle", bus.idle, 1);
    chk("coinc_overrun", bus.overrun, 1);
    chk("coinc_skipped", bus.skipped_frames, 1);
    chk("coinc_frames", bus.frame_count, 1);
    repeat (FC - 1) cycle();
    chk("no_reg_before_tick", bus.idle, 1);
    cycle();
    chk("tick_to_reg", bus.reg_action, 1);
    cycle();
    chk("gap_no_apply", bus.apply_action, 0);
    cycle();
    chk("reg_to_apply", bus.apply_action, 1);
    cycle();
    chk("apply_to_map", bus.draw_map, 1);
    bus.map_draw_done = 1;
    repeat (2) cycle();
    bus.map_draw_done = 0;
    chk("char_entry", bus.draw_char, 1);
    repeat (TO - 1) cycle();
    chk("char_hold", bus.draw_char, 1);
    cycle();
    chk("timeout_idle", bus.idle, 1);
    chk("timeout_fault", bus.draw_fault, 1);
    chk("timeout_frames", bus.frame_count, 1);
    reset = 1;
    cycle();
    reset = 0;
    repeat (300 * FC) cycle();
    chk("sat_skipped", bus.skipped_frames, 255);
    chk("sat_overrun", bus.overrun, 1);
    bus.start = 1;
    cycle();
    bus.start = 0;
    cycle();
    chk("pre_reset_map", bus.draw_map, 1);
    reset = 1;
    #1;
    chk("reset_gates_map", bus.draw_map, 0);
    cycle();
    reset = 0;
    #1;
    chk("reset_skipped", bus.skipped_frames, 0);
    chk("reset_overrun", bus.overrun, 0);
    bus.start = 1;
    cycle();
    chk("restart_init", bus.init, 1);
    for (int i = 0; i < 20000; i++) begin
      cycle();
      renderers();
      bus.start = $urandom_range(0, 3) == 0;
      reset = $urandom_range(0, 599) == 0;
    end
    reset = 0;
    cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
